// File: rtl/bus_fabric_pkg.sv
// Shared types and constants for the CPU-to-peripheral bus fabric.
package bus_fabric_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK,
    ERR
  } state_t;

  typedef enum logic {
    WAIT_FIXED,
    WAIT_READY
  } wait_mode_t;

  localparam int unsigned MAX_SLAVES       = 16;
  localparam logic [31:0] DEFAULT_ERR_DATA = 32'h0000_0000;

endpackage

// File: rtl/bus_addr_match.sv
// Base/mask window decoder: one-hot select of the lowest-index hit plus a hit flag.
module bus_addr_match #(
  parameter int unsigned       NUM_SLAVES             = 6,
  parameter int unsigned       ADDR_W                 = 32,
  parameter logic [ADDR_W-1:0] SLAVE_BASE [NUM_SLAVES] = '{default: '0},
  parameter logic [ADDR_W-1:0] SLAVE_MASK [NUM_SLAVES] = '{default: '0}
) (
  input  logic [ADDR_W-1:0]     addr_i,
  output logic [NUM_SLAVES-1:0] sel_o,
  output logic                  hit_o
);

  logic found;

  // Scan upward and stop at the first hit so overlapping windows never go multi-hot.
  always_comb begin
    sel_o = '0;
    found = 1'b0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      if (!found && ((addr_i & SLAVE_MASK[i]) == SLAVE_BASE[i])) begin
        sel_o[i] = 1'b1;
        found    = 1'b1;
      end
    end
    hit_o = found;
  end

endmodule

// File: rtl/bus_fabric.sv
// CPU bus fabric: window decode, per-slave wait states or ready handshake, registered
// read data, DTAck generation and bus-error reporting for unmapped or stalled accesses.
module bus_fabric
  import bus_fabric_pkg::*;
#(
  parameter int unsigned       NUM_SLAVES             = 6,
  parameter int unsigned       DATA_W                 = 32,
  parameter int unsigned       ADDR_W                 = 32,
  parameter logic [ADDR_W-1:0] SLAVE_BASE [NUM_SLAVES] = '{default: '0},
  parameter logic [ADDR_W-1:0] SLAVE_MASK [NUM_SLAVES] = '{default: '0},
  parameter wait_mode_t        SLAVE_MODE [NUM_SLAVES] = '{default: WAIT_FIXED},
  parameter int unsigned       SLAVE_WAIT [NUM_SLAVES] = '{default: 0},
  parameter int unsigned       TIMEOUT_CYCLES         = 255,
  parameter logic [DATA_W-1:0] ERR_DATA               = DATA_W'(DEFAULT_ERR_DATA)
) (
  input  logic                             Clock,
  input  logic                             Reset_L,
  input  logic                             AS_L,
  input  logic                             WE_L,
  input  logic [ADDR_W-1:0]                Address,
  input  logic [3:0]                       Byte_Enable,
  input  logic [NUM_SLAVES-1:0][DATA_W-1:0] Slave_DataIn,
  input  logic [NUM_SLAVES-1:0]            Slave_Ready,
  output logic [NUM_SLAVES-1:0]            Select_H,
  output logic [NUM_SLAVES-1:0]            Write_Stb_H,
  output logic [DATA_W-1:0]                DataBus_In,
  output logic                             DTAck,
  output logic                             Bus_Error,
  output logic [7:0]                       Err_Count
);

  localparam int unsigned IdxW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  state_t                  state_q, state_d;
  logic [NUM_SLAVES-1:0]   sel_q, sel_d;
  logic [NUM_SLAVES-1:0]   wstb_q, wstb_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic                    dtack_q, dtack_d;
  logic                    berr_q, berr_d;
  logic [7:0]              err_cnt_q, err_cnt_d;
  logic [3:0]              wait_cnt_q, wait_cnt_d;
  logic [TmoW-1:0]         tmo_cnt_q, tmo_cnt_d, tmo_inc;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic                    we_n_q, we_n_d;

  logic [NUM_SLAVES-1:0]   match_sel;
  logic                    match_hit;
  logic [IdxW-1:0]         match_idx;
  logic                    done;

  // Byte lanes are consumed by the slaves directly; the fabric only routes strobes.
  logic unused_be;
  assign unused_be = ^Byte_Enable;

  bus_addr_match #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_W     (ADDR_W),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_addr_match (
    .addr_i (Address),
    .sel_o  (match_sel),
    .hit_o  (match_hit)
  );

  always_comb begin
    match_idx = '0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      if (match_sel[i]) match_idx = IdxW'(i);
    end
  end

  assign done = (SLAVE_MODE[idx_q] == WAIT_READY) ? Slave_Ready[idx_q] : (wait_cnt_q == 4'd0);
  assign tmo_inc = tmo_cnt_q + TmoW'(1);

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    wstb_d     = '0;
    data_d     = data_q;
    dtack_d    = dtack_q;
    berr_d     = berr_q;
    err_cnt_d  = err_cnt_q;
    wait_cnt_d = wait_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    idx_d      = idx_q;
    we_n_d     = we_n_q;

    unique case (state_q)
      IDLE: begin
        if (!AS_L) begin
          we_n_d = WE_L;
          idx_d  = match_idx;
          if (match_hit) begin
            sel_d      = match_sel;
            wait_cnt_d = 4'(SLAVE_WAIT[match_idx]);
            tmo_cnt_d  = '0;
            state_d    = WAIT;
          end else begin
            state_d = ERR;
          end
        end
      end
      WAIT: begin
        if (AS_L) begin
          // CPU withdrew the cycle: drop the slave quietly.
          sel_d   = '0;
          state_d = IDLE;
        end else if (done) begin
          if (we_n_q) data_d = Slave_DataIn[idx_q];
          else        wstb_d = sel_q;
          dtack_d = 1'b1;
          state_d = ACK;
        end else begin
          if (wait_cnt_q != 4'd0) wait_cnt_d = wait_cnt_q - 4'd1;
          tmo_cnt_d = tmo_inc;
          if (tmo_inc == TmoW'(TIMEOUT_CYCLES)) state_d = ERR;
        end
      end
      ACK: begin
        sel_d = '0;
        if (AS_L) begin
          dtack_d = 1'b0;
          state_d = IDLE;
        end
      end
      ERR: begin
        // berr_q marks that this access has already been reported and counted.
        if (!berr_q) begin
          dtack_d = 1'b1;
          berr_d  = 1'b1;
          data_d  = ERR_DATA;
          sel_d   = '0;
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end else if (AS_L) begin
          dtack_d = 1'b0;
          berr_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      wstb_q     <= '0;
      data_q     <= '0;
      dtack_q    <= 1'b0;
      berr_q     <= 1'b0;
      err_cnt_q  <= '0;
      wait_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      idx_q      <= '0;
      we_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      wstb_q     <= wstb_d;
      data_q     <= data_d;
      dtack_q    <= dtack_d;
      berr_q     <= berr_d;
      err_cnt_q  <= err_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      idx_q      <= idx_d;
      we_n_q     <= we_n_d;
    end
  end

  assign Select_H    = sel_q;
  assign Write_Stb_H = wstb_q;
  assign DataBus_In  = data_q;
  assign DTAck       = dtack_q;
  assign Bus_Error   = berr_q;
  assign Err_Count   = err_cnt_q;

endmodule

// File: tb/tb_bus_fabric.sv
// Directed-vector bench for bus_fabric with hand-computed expectations.
module tb_bus_fabric;
  import bus_fabric_pkg::*;

  logic             clk;
  logic             rst_n;
  logic             as_l;
  logic             we_l;
  logic [31:0]      addr;
  logic [3:0]       be;
  logic [5:0][31:0] slave_data;
  logic [5:0]       slave_ready;
  logic [5:0]       select_h;
  logic [5:0]       write_stb_h;
  logic [31:0]      data_bus_in;
  logic             dtack;
  logic             bus_error;
  logic [7:0]       err_count;

  int checks   = 0;
  int failures = 0;
  int bad      = 0;

  bus_fabric #(
    .NUM_SLAVES     (6),
    .DATA_W         (32),
    .ADDR_W         (32),
    .SLAVE_BASE     ('{32'h1000_0000, 32'h0800_0000, 32'h2000_0000,
                       32'h3000_0000, 32'h1000_0000, 32'h4000_0000}),
    .SLAVE_MASK     ('{32'hF000_0000, 32'hFF00_0000, 32'hF000_0000,
                       32'hF000_0000, 32'hFF00_0000, 32'hF000_0000}),
    .SLAVE_MODE     ('{WAIT_FIXED, WAIT_FIXED, WAIT_FIXED,
                       WAIT_READY, WAIT_FIXED, WAIT_FIXED}),
    .SLAVE_WAIT     ('{1, 0, 3, 0, 0, 5}),
    .TIMEOUT_CYCLES (255),
    .ERR_DATA       (32'h0000_0000)
  ) dut (
    .Clock        (clk),
    .Reset_L      (rst_n),
    .AS_L         (as_l),
    .WE_L         (we_l),
    .Address      (addr),
    .Byte_Enable  (be),
    .Slave_DataIn (slave_data),
    .Slave_Ready  (slave_ready),
    .Select_H     (select_h),
    .Write_Stb_H  (write_stb_h),
    .DataBus_In   (data_bus_in),
    .DTAck        (dtack),
    .Bus_Error    (bus_error),
    .Err_Count    (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    as_l        = 1'b1;
    we_l        = 1'b1;
    addr        = '0;
    be          = 4'hF;
    slave_ready = '0;
    slave_data[0] = 32'hA5A5_0000;
    slave_data[1] = 32'hCAFE_F00D;
    slave_data[2] = 32'hDEAD_BEEF;
    slave_data[3] = 32'h1234_5678;
    slave_data[4] = 32'h4444_4444;
    slave_data[5] = 32'h5555_5555;
    tick();
    tick();
    check("reset_outputs", {select_h, write_stb_h, data_bus_in, dtack, bus_error, err_count}, '0);
    rst_n = 1'b1;
    tick();

    // Fixed W=0 read from slave 1.
    as_l = 1'b0; we_l = 1'b1; addr = 32'h0800_0010;
    tick();
    check("rd_w0_sel_e0", select_h, 6'b000010);
    check("rd_w0_dtack_e0", dtack, 1'b0);
    tick();
    check("rd_w0_dtack_e1", dtack, 1'b1);
    check("rd_w0_data_e1", data_bus_in, 32'hCAFE_F00D);
    tick();
    check("rd_w0_ack_hold", {select_h, dtack}, {6'b000000, 1'b1});
    as_l = 1'b1;
    tick();
    check("rd_w0_dtack_fall", dtack, 1'b0);

    // Fixed W=3 write to slave 2.
    as_l = 1'b0; we_l = 1'b0; be = 4'b0011; addr = 32'h2000_0004;
    tick();
    check("wr_w3_sel_e0", select_h, 6'b000100);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (dtack !== 1'b0 || write_stb_h !== 6'b0) bad++;
    end
    check("wr_w3_no_early_ack", bad, 0);
    tick();
    check("wr_w3_e4", {dtack, bus_error, write_stb_h}, {1'b1, 1'b0, 6'b000100});
    check("wr_w3_data_kept", data_bus_in, 32'hCAFE_F00D);
    tick();
    check("wr_w3_stb_one_cycle", {dtack, write_stb_h}, {1'b1, 6'b000000});
    as_l = 1'b1; we_l = 1'b1; be = 4'hF;
    tick();
    check("wr_w3_dtack_fall", dtack, 1'b0);

    // Ready handshake on slave 3, ready raised after 7 cycles.
    as_l = 1'b0; addr = 32'h3000_0000;
    tick();
    bad = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (dtack !== 1'b0) bad++;
    end
    check("rdy_wait_no_ack", bad, 0);
    slave_ready[3] = 1'b1;
    tick();
    check("rdy_ack", {dtack, bus_error}, {1'b1, 1'b0});
    check("rdy_data", data_bus_in, 32'h1234_5678);
    slave_ready[3] = 1'b0;
    as_l = 1'b1;
    tick();

    // Ready never comes: timeout.
    as_l = 1'b0;
    tick();
    bad = 0;
    for (int i = 1; i <= 255; i++) begin
      tick();
      if (bus_error !== 1'b0 || dtack !== 1'b0) bad++;
    end
    check("tmo_no_early_err", bad, 0);
    tick();
    check("tmo_err_e256", {dtack, bus_error}, {1'b1, 1'b1});
    check("tmo_err_data", data_bus_in, 32'h0);
    check("tmo_err_count", err_count, 8'd1);
    as_l = 1'b1;
    tick();
    check("tmo_err_clear", {dtack, bus_error}, 2'b00);

    // Unmapped address.
    as_l = 1'b0; addr = 32'hF000_0000;
    tick();
    check("unmapped_e0", {dtack, bus_error, select_h}, {1'b0, 1'b0, 6'b0});
    tick();
    check("unmapped_e1", {dtack, bus_error, err_count}, {1'b1, 1'b1, 8'd2});
    as_l = 1'b1;
    tick();
    for (int i = 0; i < 298; i++) begin
      as_l = 1'b0;
      tick();
      tick();
      as_l = 1'b1;
      tick();
    end
    check("err_count_saturate", err_count, 8'd255);

    // Overlapping windows 0 and 4: slave 0 (W=1) wins.
    as_l = 1'b0; addr = 32'h1000_0000;
    tick();
    check("overlap_sel", select_h, 6'b000001);
    tick();
    check("overlap_w1_no_ack", dtack, 1'b0);
    tick();
    check("overlap_ack_data", {dtack, data_bus_in}, {1'b1, 32'hA5A5_0000});
    as_l = 1'b1;
    tick();

    // Abort mid-WAIT on slave 5 write.
    as_l = 1'b0; we_l = 1'b0; addr = 32'h4000_0000;
    tick();
    check("abort_sel", select_h, 6'b100000);
    tick();
    tick();
    as_l = 1'b1; we_l = 1'b1;
    tick();
    check("abort_clear", {select_h, write_stb_h, dtack, bus_error, err_count},
          {6'b0, 6'b0, 1'b0, 1'b0, 8'd255});
    tick();
    check("abort_idle", {dtack, write_stb_h}, {1'b0, 6'b0});

    // Asynchronous reset mid-WAIT on slave 2, then a normal access.
    as_l = 1'b0; addr = 32'h2000_0000;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {select_h, write_stb_h, data_bus_in, dtack, bus_error, err_count}, '0);
    as_l = 1'b1;
    #1;
    rst_n = 1'b1;
    tick();
    as_l = 1'b0; addr = 32'h0800_0000;
    tick();
    tick();
    check("post_reset_access", {dtack, bus_error, data_bus_in, err_count},
          {1'b1, 1'b0, 32'hCAFE_F00D, 8'd0});
    as_l = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
